// File: rtl/nqbus_pkg.sv
// nqbus_pkg: shared nqcpu memory-bus widths and slave FSM state encodings.
package nqbus_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int CNT_W  = 4;
    typedef logic [1:0] state_t;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] ACK  = 2'd2;
endpackage

// File: rtl/bus_ram_array.sv
// bus_ram_array: single-port synchronous word RAM with registered, enabled read port.
module bus_ram_array
    import nqbus_pkg::*;
#(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_W-1:0]    wdata,
    output logic [DATA_W-1:0]    rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk)
        if (we) mem[addr] <= wdata;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rdata <= '0;
        else if (re) rdata <= mem[addr];
endmodule

// File: rtl/bus_ram.sv
// bus_ram: wait-state RAM slave on the nqcpu bus; stalls via needWait_o and
// drives data_io only during the single ACK cycle of a read.
module bus_ram
    import nqbus_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ADDR_BASE   = 16'h8000,
    parameter int                ADDR_BITS   = 10,
    parameter int                WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              re_i,
    input  logic              we_i,
    inout  wire  [DATA_W-1:0] data_io,
    output logic              needWait_o,
    output logic [1:0]        dbg_state_o
);
    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [DATA_W-1:0] rdata;
    logic              sel, req, go_ack;

    assign sel = addr_i[ADDR_W-1:ADDR_BITS] == ADDR_BASE[ADDR_W-1:ADDR_BITS];
    assign req = sel & (re_i | we_i);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: if (req) begin
                state_nx = (WAIT_STATES == 0) ? ACK : WAIT;
                cnt_nx   = CNT_W'(WAIT_STATES - 1);
            end
            WAIT: begin
                state_nx = !req ? IDLE : (cnt == '0) ? ACK : WAIT;
                cnt_nx   = (req && cnt != '0) ? cnt - 1'b1 : cnt;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end

    // Both the write commit and the read capture happen on the edge entering ACK.
    assign go_ack = (state_nx == ACK);

    bus_ram_array #(.ADDR_BITS(ADDR_BITS)) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (go_ack & we_i),
        .re    (go_ack & ~we_i),
        .addr  (addr_i[ADDR_BITS-1:0]),
        .wdata (data_io),
        .rdata (rdata)
    );

    // Gated by rst_n so the stall and the bus release the instant reset asserts.
    assign needWait_o  = rst_n & req & (state != ACK);
    assign data_io     = (rst_n && state == ACK && !we_i) ? rdata : 'z;
    assign dbg_state_o = state;
endmodule

// File: tb/tb_bus_ram.sv
// tb_bus_ram: directed checks of bus_ram at WAIT_STATES 0, 1 and 3 sharing one CPU-side stimulus.
module tb_bus_ram;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [15:0] addr = '0, wdata = '0;
    logic        re = 1'b0, we = 1'b0, drv = 1'b0;
    wire  [15:0] b0, b1, b3;
    logic        nw0, nw1, nw3;
    logic [1:0]  st0, st1, st3;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    assign b0 = drv ? wdata : 'z;
    assign b1 = drv ? wdata : 'z;
    assign b3 = drv ? wdata : 'z;

    bus_ram #(.ADDR_BASE(16'h8000), .ADDR_BITS(10), .WAIT_STATES(0)) u0 (
        .clk(clk), .rst_n(rst_n), .addr_i(addr), .re_i(re), .we_i(we),
        .data_io(b0), .needWait_o(nw0), .dbg_state_o(st0));
    bus_ram #(.ADDR_BASE(16'h8000), .ADDR_BITS(10), .WAIT_STATES(1)) u1 (
        .clk(clk), .rst_n(rst_n), .addr_i(addr), .re_i(re), .we_i(we),
        .data_io(b1), .needWait_o(nw1), .dbg_state_o(st1));
    bus_ram #(.ADDR_BASE(16'h8000), .ADDR_BITS(10), .WAIT_STATES(3)) u3 (
        .clk(clk), .rst_n(rst_n), .addr_i(addr), .re_i(re), .we_i(we),
        .data_io(b3), .needWait_o(nw3), .dbg_state_o(st3));

    // An undriven bus reads as 0 here, whatever the simulator's value model.
    function automatic logic [15:0] fl(input logic [15:0] v);
        return $isunknown(v) ? 16'h0000 : v;
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic r, input logic w, input logic [15:0] d);
        addr = a; re = r; we = w; drv = w; wdata = d;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic acc(input logic [15:0] a, input logic r, input logic w, input logic [15:0] d, input int n);
        drive(a, r, w, d);
        repeat (n) step();
        drive(16'h0, 1'b0, 1'b0, 16'h0);
        step();
    endtask

    task automatic rd3(input string tag, input logic [15:0] a, input logic [15:0] exp);
        drive(a, 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); chk({tag, "_stall"}, 16'(nw3), 16'h1); step();
        end
        @(negedge clk);
        chk({tag, "_ack_nw"}, 16'(nw3), 16'h0);
        chk({tag, "_ack_st"}, 16'(st3), 16'h2);
        chk({tag, "_data"}, b3, exp);
        step();
        drive(16'h0, 1'b0, 1'b0, 16'h0);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        chk("rst_nw1", 16'(nw1), 16'h0);
        chk("rst_st1", 16'(st1), 16'h0);
        chk("rst_st3", 16'(st3), 16'h0);
        chk("rst_bus1", fl(b1), 16'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // WS1 write BEEF to 8005: stall, stall, ACK
        drive(16'h8005, 1'b0, 1'b1, 16'hBEEF);
        @(negedge clk); chk("w1_t0_nw", 16'(nw1), 16'h1); chk("w1_t0_st", 16'(st1), 16'h0); step();
        @(negedge clk); chk("w1_t1_nw", 16'(nw1), 16'h1); chk("w1_t1_st", 16'(st1), 16'h1); step();
        @(negedge clk); chk("w1_t2_nw", 16'(nw1), 16'h0); chk("w1_t2_st", 16'(st1), 16'h2);
        chk("w1_t2_bus", b1, 16'hBEEF); step();
        drive(16'h0, 1'b0, 1'b0, 16'h0);
        @(negedge clk); chk("w1_post_st", 16'(st1), 16'h0); chk("w1_post_bus", fl(b1), 16'h0); step();

        // WS1 read 8005: data only in ACK
        drive(16'h8005, 1'b1, 1'b0, 16'h0);
        @(negedge clk); chk("r1_t0_nw", 16'(nw1), 16'h1); chk("r1_t0_bus", fl(b1), 16'h0); step();
        @(negedge clk); chk("r1_t1_nw", 16'(nw1), 16'h1); chk("r1_t1_bus", fl(b1), 16'h0); step();
        @(negedge clk); chk("r1_t2_nw", 16'(nw1), 16'h0); chk("r1_t2_st", 16'(st1), 16'h2);
        chk("r1_t2_bus", b1, 16'hBEEF); step();
        drive(16'h0, 1'b0, 1'b0, 16'h0);
        @(negedge clk); chk("r1_post_bus", fl(b1), 16'h0); chk("r1_post_st", 16'(st1), 16'h0); step();

        // Out-of-window read: no stall, no drive, no state change
        drive(16'h0010, 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rom_nw1", 16'(nw1), 16'h0);
            chk("rom_nw0", 16'(nw0), 16'h0);
            chk("rom_bus1", fl(b1), 16'h0);
            chk("rom_st1", 16'(st1), 16'h0);
            step();
        end
        drive(16'h0, 1'b0, 1'b0, 16'h0);
        step();

        // WS0 back-to-back reads after preloading 8000/8001
        acc(16'h8000, 1'b0, 1'b1, 16'h1111, 2);
        acc(16'h8001, 1'b0, 1'b1, 16'h2222, 2);
        drive(16'h8000, 1'b1, 1'b0, 16'h0);
        @(negedge clk); chk("b2b_a_nw", 16'(nw0), 16'h1); chk("b2b_a_st", 16'(st0), 16'h0); step();
        @(negedge clk); chk("b2b_a_ack_nw", 16'(nw0), 16'h0); chk("b2b_a_st2", 16'(st0), 16'h2);
        chk("b2b_a_data", b0, 16'h1111); step();
        drive(16'h8001, 1'b1, 1'b0, 16'h0);
        @(negedge clk); chk("b2b_b_nw", 16'(nw0), 16'h1); chk("b2b_b_bus", fl(b0), 16'h0); step();
        @(negedge clk); chk("b2b_b_ack_nw", 16'(nw0), 16'h0); chk("b2b_b_data", b0, 16'h2222); step();
        drive(16'h0, 1'b0, 1'b0, 16'h0);
        step();

        // WS3 aborted write leaves the prior value
        acc(16'h8002, 1'b0, 1'b1, 16'h5555, 5);
        drive(16'h8002, 1'b0, 1'b1, 16'hAAAA);
        @(negedge clk); chk("ab_t0_nw", 16'(nw3), 16'h1); chk("ab_t0_st", 16'(st3), 16'h0); step();
        @(negedge clk); chk("ab_t1_nw", 16'(nw3), 16'h1); chk("ab_t1_st", 16'(st3), 16'h1); step();
        drive(16'h8002, 1'b0, 1'b0, 16'h0);
        @(negedge clk); chk("ab_t2_nw", 16'(nw3), 16'h0); chk("ab_t2_st", 16'(st3), 16'h1); step();
        drive(16'h0, 1'b0, 1'b0, 16'h0);
        @(negedge clk); chk("ab_t3_st", 16'(st3), 16'h0); step();
        rd3("ab_rd", 16'h8002, 16'h5555);

        // WS3 reset mid-WAIT drops the write
        acc(16'h8003, 1'b0, 1'b1, 16'h3333, 5);
        drive(16'h8003, 1'b0, 1'b1, 16'h7777);
        @(negedge clk); chk("rs_t0_st", 16'(st3), 16'h0); step();
        @(negedge clk); chk("rs_t1_st", 16'(st3), 16'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rs_imm_nw", 16'(nw3), 16'h0);
        chk("rs_imm_st", 16'(st3), 16'h0);
        step();
        @(negedge clk); chk("rs_hold_nw", 16'(nw3), 16'h0); chk("rs_hold_st", 16'(st3), 16'h0); step();
        rst_n = 1'b1;
        drive(16'h0, 1'b0, 1'b0, 16'h0);
        step();
        rd3("rs_rd", 16'h8003, 16'h3333);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
